// File: rtl/divmod_pkg.sv
// rtl/divmod_pkg.sv - shared types and defaults for the restoring divider
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divmod_state_t;

  localparam int DIVMOD_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/divmod_step.sv
// rtl/divmod_step.sv - one combinational restoring shift-subtract iteration
module divmod_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // Partial remainder shifted left with the next dividend bit. Kept one bit
  // wider than the operands so a divisor with its MSB set still compares
  // correctly against a remainder whose top bit is shifted out.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  // Trial subtract; a borrow means the divisor did not fit, so restore.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, div};
    borrow   = trial[WIDTH];
    rem_next = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/divmod_unit.sv
// rtl/divmod_unit.sv - multi-cycle unsigned divider with start/busy/done handshake
module divmod_unit
  import divmod_pkg::*;
#(
  parameter int WIDTH = DIVMOD_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  divmod_state_t    state;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] div_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_next;

  divmod_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .div      (div_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Control FSM and datapath registers; quotient bits shift in from the LSB
  // of quo_reg while the dividend bits shift out of its MSB.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      div_reg     <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (b == '0) begin
              // Divide by zero short-circuits straight to a result.
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              busy        <= 1'b1;
              quo_reg     <= a;
              rem_reg     <= '0;
              div_reg     <= b;
              cnt         <= CNT_W'(WIDTH - 1);
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          quo_reg <= quo_next;
          rem_reg <= rem_next;
          if (cnt == '0) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= quo_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divmod_unit.sv
// tb/tb_divmod_unit.sv - directed self-checking bench for divmod_unit
module tb_divmod_unit;

  logic        clk;
  logic        rst;
  logic        start32;
  logic [31:0] a32, b32;
  logic        busy32, done32, dbz32;
  logic [31:0] q32, r32;
  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [7:0]  q8, r8;

  int checks;
  int failures;

  divmod_unit #(.WIDTH(32)) dut32 (
    .CLK(clk), .RST(rst), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .quotient(q32), .remainder(r32),
    .div_by_zero(dbz32)
  );

  divmod_unit #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
    .div_by_zero(dbz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one 32-bit divide and count edges after E0 until done is seen.
  task automatic run32(input logic [31:0] av, input logic [31:0] bv,
                       output int n, output logic saw_busy, output logic overlap);
    @(posedge clk); #1;
    a32 = av; b32 = bv; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; a32 = ~av; b32 = ~bv;
    n = 0; saw_busy = busy32; overlap = busy32 & done32;
    while (!done32 && n < 200) begin
      @(posedge clk); #1;
      n++;
      saw_busy = saw_busy | busy32;
      overlap  = overlap | (busy32 & done32);
    end
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, output int n);
    @(posedge clk); #1;
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~av; b8 = ~bv;
    n = 0;
    while (!done8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy32, done32, dbz32, q32, r32} !== 67'd0) begin
      failures++;
      $display("FAIL reset32 busy=%0b done=%0b dbz=%0b q=%h r=%h, required all 0",
               busy32, done32, dbz32, q32, r32);
    end
    checks++;
    if ({busy8, done8, dbz8, q8, r8} !== 19'd0) begin
      failures++;
      $display("FAIL reset8 busy=%0b done=%0b dbz=%0b q=%h r=%h, required all 0",
               busy8, done8, dbz8, q8, r8);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int n; logic sb, ov;
    run32(32'd100, 32'd7, n, sb, ov);
    checks++;
    if (n !== 32) begin failures++; $display("FAIL lat_100_7 got=%0d required=32", n); end
    checks++;
    if ({q32, r32, dbz32} !== {32'd14, 32'd2, 1'b0}) begin
      failures++; $display("FAIL res_100_7 q=%0d r=%0d dbz=%0b required q=14 r=2 dbz=0", q32, r32, dbz32);
    end
    checks++;
    if (sb !== 1'b1 || ov !== 1'b0) begin
      failures++; $display("FAIL busy_100_7 saw_busy=%0b overlap=%0b required 1/0", sb, ov);
    end
    @(posedge clk); #1;
    checks++;
    if (done32 !== 1'b0 || q32 !== 32'd14) begin
      failures++; $display("FAIL done_pulse done=%0b q=%0d required done=0 q=14", done32, q32);
    end

    run32(32'd5, 32'd9, n, sb, ov);
    checks++;
    if ({q32, r32} !== {32'd0, 32'd5}) begin
      failures++; $display("FAIL res_5_9 q=%0d r=%0d required q=0 r=5", q32, r32);
    end

    run32(32'hFFFF_FFFF, 32'd1, n, sb, ov);
    checks++;
    if ({q32, r32} !== {32'hFFFF_FFFF, 32'd0}) begin
      failures++; $display("FAIL res_max_1 q=%h r=%h required q=ffffffff r=0", q32, r32);
    end
  endtask

  task automatic test_wide_divisor;
    int n; logic sb, ov;
    run32(32'hFFFF_FFFF, 32'h8000_0001, n, sb, ov);
    checks++;
    if ({q32, r32} !== {32'd1, 32'h7FFF_FFFE}) begin
      failures++; $display("FAIL res_wide q=%h r=%h required q=1 r=7ffffffe", q32, r32);
    end
    checks++;
    if (n !== 32) begin failures++; $display("FAIL lat_wide got=%0d required=32", n); end
  endtask

  task automatic test_div_by_zero;
    int n; logic sb, ov;
    run32(32'h0000_1234, 32'd0, n, sb, ov);
    checks++;
    if (n !== 0) begin failures++; $display("FAIL dbz_lat edges_after_E0=%0d required=0", n); end
    checks++;
    if ({q32, r32, dbz32} !== {32'hFFFF_FFFF, 32'h0000_1234, 1'b1}) begin
      failures++; $display("FAIL dbz_res q=%h r=%h dbz=%0b required q=ffffffff r=1234 dbz=1", q32, r32, dbz32);
    end
    checks++;
    if (sb !== 1'b0) begin failures++; $display("FAIL dbz_busy saw_busy=%0b required=0", sb); end
    @(posedge clk); #1;
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || dbz32 !== 1'b1) begin
      failures++; $display("FAIL dbz_hold busy=%0b done=%0b dbz=%0b required 0/0/1", busy32, done32, dbz32);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    @(posedge clk); #1;
    a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    n = 0;
    while (!done32 && n < 200) begin
      if (n == 10) begin a32 = 32'd9; b32 = 32'd3; start32 = 1'b1; end
      else start32 = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start32 = 1'b0;
    checks++;
    if (n !== 32 || q32 !== 32'd14 || r32 !== 32'd2) begin
      failures++; $display("FAIL ignore_start lat=%0d q=%0d r=%0d required lat=32 q=14 r=2", n, q32, r32);
    end
    a32 = 32'd9; b32 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    checks++;
    if (busy32 !== 1'b1 || done32 !== 1'b0) begin
      failures++; $display("FAIL b2b_accept busy=%0b done=%0b required 1/0", busy32, done32);
    end
    n = 0;
    while (!done32 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 32 || q32 !== 32'd3 || r32 !== 32'd0) begin
      failures++; $display("FAIL b2b_result lat=%0d q=%0d r=%0d required lat=32 q=3 r=0", n, q32, r32);
    end
  endtask

  task automatic test_reset_mid;
    int n; logic sb, ov;
    @(posedge clk); #1;
    a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1; start32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
    @(posedge clk); #1;
    rst = 1'b0; start32 = 1'b0;
    checks++;
    if ({busy32, done32, dbz32, q32, r32} !== 67'd0) begin
      failures++; $display("FAIL mid_reset busy=%0b done=%0b dbz=%0b q=%h r=%h required all 0",
                           busy32, done32, dbz32, q32, r32);
    end
    @(posedge clk); #1;
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0) begin
      failures++; $display("FAIL reset_start_ignored busy=%0b done=%0b required 0/0", busy32, done32);
    end
    run32(32'd17, 32'd5, n, sb, ov);
    checks++;
    if (n !== 32 || q32 !== 32'd3 || r32 !== 32'd2) begin
      failures++; $display("FAIL after_reset lat=%0d q=%0d r=%0d required lat=32 q=3 r=2", n, q32, r32);
    end
  endtask

  task automatic test_width8;
    int n;
    run8(8'd200, 8'd13, n);
    checks++;
    if (n !== 8 || q8 !== 8'd15 || r8 !== 8'd5 || dbz8 !== 1'b0) begin
      failures++; $display("FAIL w8_200_13 lat=%0d q=%0d r=%0d dbz=%0b required lat=8 q=15 r=5 dbz=0",
                           n, q8, r8, dbz8);
    end
    run8(8'd255, 8'd129, n);
    checks++;
    if (q8 !== 8'd1 || r8 !== 8'd126) begin
      failures++; $display("FAIL w8_wide q=%0d r=%0d required q=1 r=126", q8, r8);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    start32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_basic();
    test_wide_divisor();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
